// File: rtl/vram_fill_if.sv
// Command and VRAM write-port bundle for the rectangle-fill writer.
// The master side issues fill commands; the slave side is the filler driving VRAM.
interface vram_fill_if #(
    parameter int AW = 18
);
    logic          start;
    logic          abort;
    logic [9:0]    x0;
    logic [9:0]    y0;
    logic [9:0]    w;
    logic [9:0]    h;
    logic [7:0]    fill;
    logic          busy;
    logic          done;
    logic [AW-1:0] vram_ad;
    logic [7:0]    vram_d;
    logic          vram_we;

    modport master (
        output start, abort, x0, y0, w, h, fill,
        input  busy, done, vram_ad, vram_d, vram_we
    );

    modport slave (
        input  start, abort, x0, y0, w, h, fill,
        output busy, done, vram_ad, vram_d, vram_we
    );
endinterface

// File: rtl/vram_fill.sv
// Rectangle-fill writer: walks a w x h byte rectangle in row-major order and
// emits one VRAM byte write per clock, all outputs registered.
module vram_fill #(
    parameter int PITCH = 400,
    parameter int AW    = 18
) (
    input  logic       clock,
    input  logic       reset_n,
    vram_fill_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETUP, FILL, FINISH} state_t;

    state_t        state_q, state_d;
    logic [9:0]    x0_q, x0_d, y0_q, y0_d;
    logic [9:0]    w_q, w_d, h_q, h_d;
    logic [9:0]    cx_q, cx_d, cy_q, cy_d;
    logic [7:0]    fill_q, fill_d;
    logic [AW-1:0] row_base_q, row_base_d;
    logic [AW-1:0] vram_ad_q, vram_ad_d;
    logic [7:0]    vram_d_q, vram_d_d;
    logic          vram_we_q, vram_we_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Outputs are a registered image of the current state's behaviour, so
    // they lag the state register by exactly one cycle.
    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        w_d        = w_q;
        h_d        = h_q;
        fill_d     = fill_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        row_base_d = row_base_q;
        vram_ad_d  = vram_ad_q;
        vram_d_d   = vram_d_q;
        vram_we_d  = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x0_d    = bus.x0;
                    y0_d    = bus.y0;
                    w_d     = bus.w;
                    h_d     = bus.h;
                    fill_d  = bus.fill;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                busy_d     = 1'b1;
                row_base_d = AW'(y0_q) * AW'(PITCH) + AW'(x0_q);
                cx_d       = '0;
                cy_d       = '0;
                if (bus.abort || w_q == '0 || h_q == '0) begin
                    state_d = FINISH;
                end else begin
                    state_d = FILL;
                end
            end
            FILL: begin
                busy_d = 1'b1;
                if (bus.abort) begin
                    state_d = FINISH;
                end else begin
                    vram_we_d = 1'b1;
                    vram_ad_d = row_base_q + AW'(cx_q);
                    vram_d_d  = fill_q;
                    // End of a row: rows are contiguous at a fixed pitch, no clipping.
                    if (cx_q == w_q - 10'd1) begin
                        cx_d       = '0;
                        row_base_d = row_base_q + AW'(PITCH);
                        if (cy_q == h_q - 10'd1) begin
                            state_d = FINISH;
                        end else begin
                            cy_d = cy_q + 10'd1;
                        end
                    end else begin
                        cx_d = cx_q + 10'd1;
                    end
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            x0_q       <= '0;
            y0_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            fill_q     <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            row_base_q <= '0;
            vram_ad_q  <= '0;
            vram_d_q   <= '0;
            vram_we_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            w_q        <= w_d;
            h_q        <= h_d;
            fill_q     <= fill_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            row_base_q <= row_base_d;
            vram_ad_q  <= vram_ad_d;
            vram_d_q   <= vram_d_d;
            vram_we_q  <= vram_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.vram_ad = vram_ad_q;
    assign bus.vram_d  = vram_d_q;
    assign bus.vram_we = vram_we_q;
endmodule

// File: tb/tb_vram_fill.sv
// Self-checking bench for vram_fill: a scoreboard queue holds the expected
// write stream, and per-scenario tasks check timing, counts and control outputs.
module tb_vram_fill;
    localparam int AW    = 18;
    localparam int PITCH = 400;

    typedef struct packed {
        logic [AW-1:0] ad;
        logic [7:0]    d;
    } wr_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    vram_fill_if #(.AW(AW)) bus ();

    vram_fill #(.PITCH(PITCH), .AW(AW)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    wr_t exp_q[$];
    int  assertions   = 0;
    int  failures     = 0;
    int  wr_count     = 0;
    int  done_count   = 0;
    int  first_wr_cyc = 0;
    int  last_wr_cyc  = 0;
    int  done_cyc     = 0;
    int  start_cyc    = 0;
    bit  arm_first    = 1'b0;

    task automatic set_cmd(input int x0, input int y0, input int w, input int h, input logic [7:0] f);
        bus.x0   = 10'(x0);
        bus.y0   = 10'(y0);
        bus.w    = 10'(w);
        bus.h    = 10'(h);
        bus.fill = f;
    endtask

    // Reference model: plain row-major address walk, modulo 2^AW.
    task automatic push_expected(input int x0, input int y0, input int w, input int h, input logic [7:0] f);
        wr_t e;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                e.ad = AW'((y0 * PITCH + x0 + r * PITCH + c) % (1 << AW));
                e.d  = f;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic issue(input int x0, input int y0, input int w, input int h,
                         input logic [7:0] f, input bit expect_writes);
        @(negedge clock);
        set_cmd(x0, y0, w, h, f);
        bus.start = 1'b1;
        if (expect_writes) push_expected(x0, y0, w, h, f);
        arm_first = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int base;
        base = done_count;
        ok   = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            #1;
            if (done_count != base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_writes(input int base, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            #1;
            if (wr_count - base >= n) break;
        end
    endtask

    task automatic test_reset();
        #12;
        assertions++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b, required 0", bus.busy); end
        assertions++; if (bus.done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b, required 0", bus.done); end
        assertions++; if (bus.vram_we !== 1'b0) begin failures++; $display("[TB] FAIL reset_we: got %b, required 0", bus.vram_we); end
        assertions++; if (bus.vram_ad !== '0) begin failures++; $display("[TB] FAIL reset_ad: got %0d, required 0", bus.vram_ad); end
        assertions++; if (bus.vram_d !== 8'h00) begin failures++; $display("[TB] FAIL reset_d: got %h, required 00", bus.vram_d); end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_fill_3x2();
        int w0;
        bit ok;
        w0 = wr_count;
        issue(5, 2, 3, 2, 8'hA5, 1'b1);
        @(posedge clock);
        #1;
        assertions++; if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL fill_busy_after_setup: got %b, required 1", bus.busy); end
        assertions++; if (bus.vram_we !== 1'b0) begin failures++; $display("[TB] FAIL fill_we_in_setup: got %b, required 0", bus.vram_we); end
        wait_done(40, ok);
        assertions++; if (!ok) begin failures++; $display("[TB] FAIL fill_done_timeout: got no done, required done"); end
        assertions++; if (done_cyc - start_cyc !== 8) begin failures++; $display("[TB] FAIL fill_done_latency: got %0d, required 8", done_cyc - start_cyc); end
        assertions++; if (first_wr_cyc - start_cyc !== 2) begin failures++; $display("[TB] FAIL fill_first_write: got %0d, required 2", first_wr_cyc - start_cyc); end
        assertions++; if (wr_count - w0 !== 6) begin failures++; $display("[TB] FAIL fill_write_count: got %0d, required 6", wr_count - w0); end
        assertions++; if (last_wr_cyc - first_wr_cyc + 1 !== 6) begin failures++; $display("[TB] FAIL fill_write_span: got %0d, required 6", last_wr_cyc - first_wr_cyc + 1); end
        assertions++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL fill_busy_at_done: got %b, required 0", bus.busy); end
        assertions++; if (exp_q.size() !== 0) begin failures++; $display("[TB] FAIL fill_missing_writes: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_noop();
        int w0;
        w0 = wr_count;
        issue(0, 0, 0, 4, 8'h77, 1'b0);
        @(posedge clock);
        #1;
        assertions++; if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL noop_busy_n1: got %b, required 1", bus.busy); end
        assertions++; if (bus.done !== 1'b0) begin failures++; $display("[TB] FAIL noop_done_n1: got %b, required 0", bus.done); end
        @(posedge clock);
        #1;
        assertions++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL noop_busy_n2: got %b, required 0", bus.busy); end
        assertions++; if (bus.done !== 1'b1) begin failures++; $display("[TB] FAIL noop_done_n2: got %b, required 1", bus.done); end
        repeat (3) @(negedge clock);
        assertions++; if (wr_count - w0 !== 0) begin failures++; $display("[TB] FAIL noop_writes: got %0d, required 0", wr_count - w0); end
    endtask

    task automatic test_wrap();
        int w0;
        bit ok;
        w0 = wr_count;
        issue(400, 655, 4, 1, 8'h3C, 1'b1);
        wait_done(40, ok);
        assertions++; if (!ok) begin failures++; $display("[TB] FAIL wrap_done_timeout: got no done, required done"); end
        assertions++; if (done_cyc - start_cyc !== 6) begin failures++; $display("[TB] FAIL wrap_done_latency: got %0d, required 6", done_cyc - start_cyc); end
        assertions++; if (wr_count - w0 !== 4) begin failures++; $display("[TB] FAIL wrap_write_count: got %0d, required 4", wr_count - w0); end
        assertions++; if (exp_q.size() !== 0) begin failures++; $display("[TB] FAIL wrap_missing_writes: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_abort();
        int w0, d0;
        bit ok;
        w0 = wr_count;
        d0 = done_count;
        issue(7, 3, 10, 10, 8'h5A, 1'b1);
        wait_writes(w0, 15, 60);
        assertions++; if (wr_count - w0 !== 15) begin failures++; $display("[TB] FAIL abort_reach_15: got %0d, required 15", wr_count - w0); end
        bus.abort = 1'b1;
        @(posedge clock);
        #1;
        bus.abort = 1'b0;
        assertions++; if (bus.vram_we !== 1'b0) begin failures++; $display("[TB] FAIL abort_we_drop: got %b, required 0", bus.vram_we); end
        wait_done(10, ok);
        assertions++; if (!ok) begin failures++; $display("[TB] FAIL abort_done_timeout: got no done, required done"); end
        repeat (4) @(negedge clock);
        #1;
        assertions++; if (wr_count - w0 !== 15) begin failures++; $display("[TB] FAIL abort_write_count: got %0d, required 15", wr_count - w0); end
        assertions++; if (done_count - d0 !== 1) begin failures++; $display("[TB] FAIL abort_done_count: got %0d, required 1", done_count - d0); end
        assertions++; if (exp_q.size() !== 85) begin failures++; $display("[TB] FAIL abort_left_in_queue: got %0d, required 85", exp_q.size()); end
        exp_q.delete();
        w0 = wr_count;
        issue(0, 1, 2, 1, 8'hC3, 1'b1);
        wait_done(20, ok);
        assertions++; if (wr_count - w0 !== 2 || !ok) begin failures++; $display("[TB] FAIL abort_restart: got %0d writes done=%0b, required 2 writes and done", wr_count - w0, ok); end
        assertions++; if (exp_q.size() !== 0) begin failures++; $display("[TB] FAIL abort_restart_queue: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_ignored_start();
        int w0, d0;
        bit ok;
        w0 = wr_count;
        d0 = done_count;
        issue(10, 1, 4, 2, 8'h11, 1'b1);
        repeat (3) @(posedge clock);
        #1;
        set_cmd(0, 0, 1, 1, 8'hFF);
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        wait_done(40, ok);
        assertions++; if (!ok) begin failures++; $display("[TB] FAIL ign_done_timeout: got no done, required done"); end
        assertions++; if (done_cyc - start_cyc !== 10) begin failures++; $display("[TB] FAIL ign_done_latency: got %0d, required 10", done_cyc - start_cyc); end
        repeat (6) @(negedge clock);
        #1;
        assertions++; if (wr_count - w0 !== 8) begin failures++; $display("[TB] FAIL ign_write_count: got %0d, required 8", wr_count - w0); end
        assertions++; if (done_count - d0 !== 1) begin failures++; $display("[TB] FAIL ign_done_count: got %0d, required 1", done_count - d0); end
        assertions++; if (exp_q.size() !== 0) begin failures++; $display("[TB] FAIL ign_missing_writes: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int w0, prev_last;
        bit ok;
        w0 = wr_count;
        issue(20, 4, 3, 1, 8'h96, 1'b1);
        wait_writes(w0, 3, 20);
        // Start during the last write cycle lands on the FINISH edge and is dropped.
        set_cmd(1, 1, 5, 5, 8'h00);
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        assertions++; if (bus.done !== 1'b1) begin failures++; $display("[TB] FAIL b2b_done_cycle: got %b, required 1", bus.done); end
        prev_last = last_wr_cyc;
        set_cmd(30, 4, 2, 1, 8'h69);
        bus.start = 1'b1;
        push_expected(30, 4, 2, 1, 8'h69);
        arm_first = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        start_cyc = cyc;
        wait_done(20, ok);
        assertions++; if (!ok) begin failures++; $display("[TB] FAIL b2b_done_timeout: got no done, required done"); end
        assertions++; if (first_wr_cyc - prev_last !== 4) begin failures++; $display("[TB] FAIL b2b_gap: got %0d, required 4", first_wr_cyc - prev_last); end
        assertions++; if (wr_count - w0 !== 5) begin failures++; $display("[TB] FAIL b2b_write_count: got %0d, required 5", wr_count - w0); end
        assertions++; if (exp_q.size() !== 0) begin failures++; $display("[TB] FAIL b2b_missing_writes: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_fill();
        int w0, d0;
        bit ok;
        w0 = wr_count;
        issue(0, 10, 10, 10, 8'hE7, 1'b1);
        wait_writes(w0, 5, 40);
        d0 = done_count;
        reset_n = 1'b0;
        #1;
        assertions++; if (bus.vram_we !== 1'b0) begin failures++; $display("[TB] FAIL rst_we_async: got %b, required 0", bus.vram_we); end
        assertions++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy_async: got %b, required 0", bus.busy); end
        assertions++; if (bus.done !== 1'b0) begin failures++; $display("[TB] FAIL rst_done_async: got %b, required 0", bus.done); end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge clock);
        #1;
        assertions++; if (done_count - d0 !== 0) begin failures++; $display("[TB] FAIL rst_no_done: got %0d, required 0", done_count - d0); end
        w0 = wr_count;
        issue(2, 2, 3, 1, 8'h42, 1'b1);
        wait_done(20, ok);
        assertions++; if (!ok || done_cyc - start_cyc !== 5) begin failures++; $display("[TB] FAIL rst_restart_latency: got %0d done=%0b, required 5", done_cyc - start_cyc, ok); end
        assertions++; if (wr_count - w0 !== 3) begin failures++; $display("[TB] FAIL rst_restart_writes: got %0d, required 3", wr_count - w0); end
        assertions++; if (exp_q.size() !== 0) begin failures++; $display("[TB] FAIL rst_restart_queue: got %0d left, required 0", exp_q.size()); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        set_cmd(0, 0, 0, 0, 8'h00);

        // Scoreboard monitor: every observed write must match the head of the queue.
        fork
            begin
                wr_t e;
                forever begin
                    @(negedge clock);
                    if (reset_n) begin
                        if (bus.vram_we === 1'b1) begin
                            wr_count++;
                            last_wr_cyc = cyc;
                            if (arm_first) begin
                                first_wr_cyc = cyc;
                                arm_first    = 1'b0;
                            end
                            assertions++;
                            if (exp_q.size() == 0) begin
                                failures++;
                                $display("[TB] FAIL write_unexpected: got ad=%0d d=%h, required no write", bus.vram_ad, bus.vram_d);
                            end else begin
                                e = exp_q.pop_front();
                                if (bus.vram_ad !== e.ad || bus.vram_d !== e.d) begin
                                    failures++;
                                    $display("[TB] FAIL write_data: got ad=%0d d=%h, required ad=%0d d=%h", bus.vram_ad, bus.vram_d, e.ad, e.d);
                                end
                            end
                        end
                        if (bus.done === 1'b1) begin
                            done_count++;
                            done_cyc = cyc;
                        end
                    end
                end
            end
        join_none

        test_reset();
        test_fill_3x2();
        test_noop();
        test_wrap();
        test_abort();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_fill();

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, required completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
